// File: rtl/scan_pkg.sv
// scan_pkg: shared definitions for the scan frame sequencer.
//   state_t   : 3-bit sequencer state encoding
//   FRAME_HDR : first byte of every frame
//   hi_byte   : upper byte of a zero-extended 16-bit sample
package scan_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_HDR      = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_CONV     = 3'd3,
      ST_WAIT_ADC = 3'd4,
      ST_SEND_HI  = 3'd5,
      ST_SEND_LO  = 3'd6,
      ST_NEXT     = 3'd7
   } state_t;

   localparam logic [7:0] FRAME_HDR = 8'hA5;

   function automatic logic [7:0] hi_byte(input logic [15:0] s);
      return s[15:8];
   endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer: 8-bit down-counter.
//   clk_core, reset (async active-low)
//   load/load_val : reload the count (load wins over en)
//   en            : decrement while non-zero
//   done          : count has reached zero
module settle_timer (
   input  logic       clk_core,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       en,
   output logic       done
);

   logic [7:0] count;

   always_ff @(posedge clk_core or negedge reset) begin
      if (!reset)                  count <= '0;
      else if (load)               count <= load_val;
      else if (en && count != '0)  count <= count - 8'd1;
   end

   assign done = (count == '0);

endmodule

// File: rtl/scan_frame_sequencer.sv
// scan_frame_sequencer: one full matrix scan per trigger rising edge.
//   clk_core, reset (async active-low)
//   trigger_in          : start request, rising edge only
//   adc_done/adc_data   : conversion result strobe and sample
//   tx_ready            : UART accepts tx_data this cycle
//   row_sel/col_sel     : matrix selects, row-major scan
//   adc_start           : one-cycle conversion start
//   tx_valid/tx_data    : byte stream A5, then {hi,lo} per pixel
//   busy                : frame in progress
//   overrun             : trigger edge dropped while busy
module scan_frame_sequencer
   import scan_pkg::*;
#(
   parameter int ROWS          = 16,
   parameter int COLS          = 16,
   parameter int DATA_W        = 12,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic                    clk_core,
   input  logic                    reset,
   input  logic                    trigger_in,
   input  logic                    adc_done,
   input  logic [DATA_W-1:0]       adc_data,
   input  logic                    tx_ready,
   output logic [$clog2(ROWS)-1:0] row_sel,
   output logic [$clog2(COLS)-1:0] col_sel,
   output logic                    adc_start,
   output logic                    tx_valid,
   output logic [7:0]              tx_data,
   output logic                    busy,
   output logic                    overrun
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   state_t      state;
   logic        trigger_q;
   logic        trig_edge;
   logic [7:0]  lo_q;
   logic [15:0] adc_ext;
   logic        last_col;
   logic        last_row;
   logic        tmr_load;
   logic        tmr_done;

   assign trig_edge = trigger_in & ~trigger_q;
   assign adc_ext   = 16'(adc_data);
   assign last_col  = (col_sel == CW'(COLS - 1));
   assign last_row  = (row_sel == RW'(ROWS - 1));

   // Reloading every cycle in HDR/NEXT is harmless: the count only
   // matters once SETTLE is entered, which always follows one of them.
   assign tmr_load = (state == ST_HDR) || (state == ST_NEXT);

   settle_timer u_settle (
      .clk_core (clk_core),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (SETTLE_LOAD),
      .en       (state == ST_SETTLE),
      .done     (tmr_done)
   );

   always_ff @(posedge clk_core or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         trigger_q <= 1'b1;   // a trigger held high through reset is not an edge
         lo_q      <= '0;
         row_sel   <= '0;
         col_sel   <= '0;
         adc_start <= 1'b0;
         tx_valid  <= 1'b0;
         tx_data   <= '0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         trigger_q <= trigger_in;
         adc_start <= 1'b0;
         overrun   <= trig_edge && (state != ST_IDLE);
         unique case (state)
            ST_IDLE: if (trig_edge) begin
               state    <= ST_HDR;
               busy     <= 1'b1;
               tx_valid <= 1'b1;
               tx_data  <= FRAME_HDR;
            end
            ST_HDR: if (tx_ready) begin
               state    <= ST_SETTLE;
               tx_valid <= 1'b0;
               tx_data  <= '0;
            end
            ST_SETTLE: if (tmr_done) begin
               state     <= ST_CONV;
               adc_start <= 1'b1;
            end
            ST_CONV: state <= ST_WAIT_ADC;
            ST_WAIT_ADC: if (adc_done) begin
               state    <= ST_SEND_HI;
               lo_q     <= adc_data[7:0];
               tx_valid <= 1'b1;
               tx_data  <= hi_byte(adc_ext);
            end
            ST_SEND_HI: if (tx_ready) begin
               state   <= ST_SEND_LO;
               tx_data <= lo_q;
            end
            ST_SEND_LO: if (tx_ready) begin
               state    <= ST_NEXT;
               tx_valid <= 1'b0;
               tx_data  <= '0;
            end
            ST_NEXT: begin
               if (last_col && last_row) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  row_sel <= '0;
                  col_sel <= '0;
               end else if (last_col) begin
                  state   <= ST_SETTLE;
                  col_sel <= '0;
                  row_sel <= row_sel + RW'(1);
               end else begin
                  state   <= ST_SETTLE;
                  col_sel <= col_sel + CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
